// File: rtl/layer2_operand_loader.sv
// -----------------------------------------------------------------------------
// layer2_operand_loader
//
// Producer-side sequencer for the layer-2 neuron datapath. It collects one
// image's serial 8-bit layer-1 activations and quantises each to a 4-bit
// feature. Then, for every output neuron in turn, it streams that neuron's
// weights from an external synchronous ROM. It presents the packed feature
// vector, the weight vector and the bias on a valid/ready handshake.
//
// Ports
//   clk3            sole clock, rising edge
//   reset1          synchronous active-high reset
//   start           begin a new image (honoured only while idle)
//   act_valid       activation beat valid
//   act_data        unsigned 8-bit activation, index 0 first
//   act_ready       high exactly while collecting activations
//   rom_en          weight ROM read enable
//   rom_addr        weight ROM address = neuron_idx*hidden_layer + j
//   rom_data        ROM read data, valid the cycle after rom_en
//   biases          static bias table, neuron n at [3n +: 3]
//   input_features  packed 4-bit features, slot k at [4k +: 4]
//   input_weights   packed signed weights, slot k at [4k +: 4]
//   bias            bias of the presented neuron (0 when not presenting)
//   neuron_idx      current output neuron
//   op_valid        operands valid
//   op_ready        consumer accepts operands
//   busy            high in every state except idle
//   done            one-cycle pulse after the last neuron's transfer
// -----------------------------------------------------------------------------
module layer2_operand_loader #(
   parameter int hidden_layer = 100,
   parameter int num_out      = 10,
   parameter int input_bit    = 4,
   parameter int weight_bit   = 4,
   parameter int feat_shift   = 3,
   parameter int addr_w       = 10
) (
   input  logic                               clk3,
   input  logic                               reset1,
   input  logic                               start,
   input  logic                               act_valid,
   input  logic [7:0]                         act_data,
   output logic                               act_ready,
   output logic                               rom_en,
   output logic [addr_w-1:0]                  rom_addr,
   input  logic [weight_bit-1:0]              rom_data,
   input  logic [3*num_out-1:0]               biases,
   output logic [input_bit*hidden_layer-1:0]  input_features,
   output logic [weight_bit*hidden_layer-1:0] input_weights,
   output logic [2:0]                         bias,
   output logic [3:0]                         neuron_idx,
   output logic                               op_valid,
   input  logic                               op_ready,
   output logic                               busy,
   output logic                               done
);

   localparam int CNT_W = $clog2(hidden_layer + 1);

   localparam logic [CNT_W-1:0] LAST_K = CNT_W'(hidden_layer - 1);
   localparam logic [CNT_W-1:0] LAST_J = CNT_W'(hidden_layer);
   localparam logic [3:0]       LAST_N = 4'(num_out - 1);
   localparam logic [7:0]       Q_MAX  = 8'((1 << input_bit) - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_FETCH,
      S_PRESENT
   } state_t;

   state_t r_state;
   state_t w_next_state;

   logic [CNT_W-1:0]      r_k;              // activation slot being filled
   logic [CNT_W-1:0]      r_j;              // fetch cycle counter, 0..hidden_layer
   logic [3:0]            r_neuron_idx;
   logic                  r_done;
   logic [input_bit-1:0]  r_feat [hidden_layer];
   logic [weight_bit-1:0] r_wt   [hidden_layer];

   logic                  w_beat;
   logic                  w_last_beat;
   logic                  w_fetch_end;
   logic                  w_rom_fetch;
   logic                  w_xfer;
   logic                  w_last_neuron;
   logic [CNT_W-1:0]      w_wslot;
   logic [7:0]            w_shifted;
   logic [input_bit-1:0]  w_q;

   // -------------------------------------------------------------------------
   // Decode
   // -------------------------------------------------------------------------
   assign w_beat        = (r_state == S_COLLECT) && act_valid;
   assign w_last_beat   = w_beat && (r_k == LAST_K);
   assign w_fetch_end   = (r_state == S_FETCH) && (r_j == LAST_J);
   // The last fetch cycle only captures the final ROM word; no new read.
   assign w_rom_fetch   = (r_state == S_FETCH) && (r_j != LAST_J);
   assign w_xfer        = (r_state == S_PRESENT) && op_ready;
   assign w_last_neuron = (r_neuron_idx == LAST_N);
   // ROM data lags the address by one cycle, so fetch cycle j fills slot j-1.
   assign w_wslot       = r_j - 1'b1;

   // Quantise: shift, then saturate to the largest feature code.
   assign w_shifted = act_data >> feat_shift;
   assign w_q       = (w_shifted > Q_MAX) ? Q_MAX[input_bit-1:0]
                                          : w_shifted[input_bit-1:0];

   // -------------------------------------------------------------------------
   // FSM
   // -------------------------------------------------------------------------
   // NOTE: every clocked process uses non-blocking assignments so that all
   // registers update from the same pre-edge values, whatever the order of
   // the processes.
   always_ff @(posedge clk3) begin
      if (reset1) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // NOTE: the default is assigned first so that every path through the
   // case drives w_next_state and no latch is inferred.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:    if (start)        w_next_state = S_COLLECT;
         S_COLLECT: if (w_last_beat)  w_next_state = S_FETCH;
         S_FETCH:   if (w_fetch_end)  w_next_state = S_PRESENT;
         S_PRESENT: if (w_xfer)       w_next_state = w_last_neuron ? S_IDLE : S_FETCH;
         default:                     w_next_state = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Counters and done pulse
   // -------------------------------------------------------------------------
   always_ff @(posedge clk3) begin
      if (reset1) begin
         r_k          <= '0;
         r_j          <= '0;
         r_neuron_idx <= '0;
         r_done       <= 1'b0;
      end else begin
         r_done <= w_xfer && w_last_neuron;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_k          <= '0;
                  r_j          <= '0;
                  r_neuron_idx <= '0;
               end
            end
            S_COLLECT: begin
               if (w_beat) begin
                  r_k <= r_k + 1'b1;
               end
               if (w_last_beat) begin
                  r_j <= '0;
               end
            end
            S_FETCH: begin
               if (!w_fetch_end) begin
                  r_j <= r_j + 1'b1;
               end
            end
            S_PRESENT: begin
               if (w_xfer) begin
                  r_j <= '0;
                  if (!w_last_neuron) begin
                     r_neuron_idx <= r_neuron_idx + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Feature and weight storage
   // -------------------------------------------------------------------------
   // NOTE: these arrays are cleared on reset on purpose. The packed vectors
   // are ports that must read zero after reset. A plain storage RAM would
   // normally be left unreset.
   always_ff @(posedge clk3) begin
      if (reset1) begin
         for (int i = 0; i < hidden_layer; i++) begin
            r_feat[i] <= '0;
            r_wt[i]   <= '0;
         end
      end else begin
         if (w_beat) begin
            r_feat[r_k] <= w_q;
         end
         // Gated by state, so a read issued just before reset never lands.
         if ((r_state == S_FETCH) && (r_j != '0)) begin
            r_wt[w_wslot] <= rom_data;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   always_comb begin
      input_features = '0;
      input_weights  = '0;
      for (int i = 0; i < hidden_layer; i++) begin
         input_features[i*input_bit +: input_bit]   = r_feat[i];
         input_weights[i*weight_bit +: weight_bit]  = r_wt[i];
      end
   end

   always_comb begin
      bias = '0;
      if (r_state == S_PRESENT) begin
         bias = biases[3*r_neuron_idx +: 3];
      end
   end

   assign rom_en     = w_rom_fetch;
   assign rom_addr   = w_rom_fetch ? (addr_w'(r_neuron_idx) * addr_w'(hidden_layer) + addr_w'(r_j))
                                   : '0;
   assign act_ready  = (r_state == S_COLLECT);
   assign op_valid   = (r_state == S_PRESENT);
   assign busy       = (r_state != S_IDLE);
   assign neuron_idx = r_neuron_idx;
   assign done       = r_done;

endmodule

// File: tb/tb_layer2_operand_loader.sv
// -----------------------------------------------------------------------------
// Testbench for layer2_operand_loader. Expected features, weights, biases,
// ROM address sequences and cycle timing come from plain arithmetic on the
// stimulus tables held here, not from the design.
// -----------------------------------------------------------------------------
module tb_layer2_operand_loader;

   localparam int H = 100;
   localparam int N = 10;

   logic           clk3 = 1'b0;
   logic           reset1;
   logic           start;
   logic           act_valid;
   logic [7:0]     act_data;
   logic           act_ready;
   logic           rom_en;
   logic [9:0]     rom_addr;
   logic [3:0]     rom_data;
   logic [3*N-1:0] biases;
   logic [4*H-1:0] input_features;
   logic [4*H-1:0] input_weights;
   logic [2:0]     bias;
   logic [3:0]     neuron_idx;
   logic           op_valid;
   logic           op_ready;
   logic           busy;
   logic           done;

   layer2_operand_loader dut (
      .clk3           (clk3),
      .reset1         (reset1),
      .start          (start),
      .act_valid      (act_valid),
      .act_data       (act_data),
      .act_ready      (act_ready),
      .rom_en         (rom_en),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .biases         (biases),
      .input_features (input_features),
      .input_weights  (input_weights),
      .bias           (bias),
      .neuron_idx     (neuron_idx),
      .op_valid       (op_valid),
      .op_ready       (op_ready),
      .busy           (busy),
      .done           (done)
   );

   always #5 clk3 = ~clk3;

   int          n_tests  = 0;
   int          n_fail   = 0;
   int          step_cnt = 0;
   logic [3:0]  rom_mem [1024];
   int          act_tbl  [H];
   int          bias_tbl [N];
   int          addr_log [$];

   // Synchronous ROM with one cycle of read latency; also logs every read.
   always @(posedge clk3) begin
      if (rom_en) begin
         rom_data <= rom_mem[rom_addr];
         addr_log.push_back(int'(rom_addr));
      end
   end

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One cycle; inputs are driven and outputs observed at the falling edge.
   task automatic step();
      @(negedge clk3);
      step_cnt++;
   endtask

   function automatic int quant(input int a);
      int q;
      q = a / 8;
      return (q > 15) ? 15 : q;
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, "_act_ready"}, act_ready, 0);
      check({tag, "_rom_en"}, rom_en, 0);
      check({tag, "_rom_addr"}, rom_addr, 0);
      check({tag, "_features"}, input_features, 0);
      check({tag, "_weights"}, input_weights, 0);
      check({tag, "_bias"}, bias, 0);
      check({tag, "_neuron_idx"}, neuron_idx, 0);
      check({tag, "_op_valid"}, op_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
   endtask

   // Run one image. gaps: random act_valid/op_ready back-pressure.
   // bp_first: hold op_ready low 20 cycles on neuron 0. timing: continuous
   // stimulus, op_ready high, cycle-exact checks. abort_n: reset mid-fetch.
   task automatic run_image(input bit gaps, input bit bp_first, input bit timing, input int abort_n);
      int             k;
      int             t0;
      int             guard;
      int             bad;
      logic [4*H-1:0] ef;
      logic [4*H-1:0] ew;
      logic [2:0]     eb;

      for (int n = 0; n < N; n++) biases[3*n +: 3] = 3'(bias_tbl[n]);
      for (int i = 0; i < H; i++) ef[4*i +: 4] = 4'(quant(act_tbl[i]));
      addr_log.delete();

      start    = 1'b1;
      op_ready = timing;
      t0       = step_cnt;
      step();
      start = 1'b0;
      check("busy_rise", busy, 1);
      check("act_ready_collect", act_ready, 1);

      k     = 0;
      guard = 0;
      while (k < H && guard < 1000) begin
         act_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         act_data  = act_valid ? 8'(act_tbl[k]) : 8'($urandom);
         if (act_valid && act_ready) k++;
         step();
         guard++;
      end
      check("collect_count", k, H);
      // Beats offered outside collection must be ignored.
      act_valid = 1'b1;
      act_data  = 8'($urandom);
      check("act_ready_low", act_ready, 0);

      for (int n = 0; n < N; n++) begin
         int fetch_at;
         fetch_at = step_cnt;
         check("fetch_starts", rom_en, 1);

         if (n == abort_n) begin
            repeat (30) step();
            check("abort_in_fetch", rom_en, 1);
            reset1 = 1'b1;
            step();
            check_idle_outputs("abort");
            reset1 = 1'b0;
            step();
            check("abort_stays_idle", busy, 0);
            act_valid = 1'b0;
            return;
         end

         guard = 0;
         while (!op_valid && guard < 400) begin
            start    = (timing && n == 3 && guard == 5);
            act_data = 8'($urandom);
            step();
            guard++;
         end
         start = 1'b0;
         check("op_valid_timeout", op_valid, 1);
         check("fetch_len", step_cnt - fetch_at, H + 1);

         for (int i = 0; i < H; i++) ew[4*i +: 4] = rom_mem[n*H + i];
         eb = 3'(bias_tbl[n]);
         check("features", input_features, ef);
         check("weights", input_weights, ew);
         check("bias", bias, eb);
         check("neuron_idx", neuron_idx, n);
         check("rom_idle_present", rom_en, 0);
         check("busy_present", busy, 1);

         check("addr_count", addr_log.size(), H);
         bad = 0;
         for (int i = 0; i < addr_log.size(); i++) begin
            if (addr_log[i] != n*H + i) bad++;
         end
         check("addr_seq", bad, 0);
         addr_log.delete();

         if (bp_first && n == 0) begin
            op_ready = 1'b0;
            bad = 0;
            repeat (20) begin
               step();
               if (op_valid !== 1'b1 || input_features !== ef || input_weights !== ew ||
                   bias !== eb || neuron_idx !== 4'(n)) bad++;
            end
            check("bp_stable", bad, 0);
            op_ready = 1'b1;
            step();
            op_ready = 1'b0;
         end else if (gaps) begin
            op_ready = 1'b0;
            repeat ($urandom_range(0, 3)) step();
            check("hold_valid", op_valid, 1);
            op_ready = 1'b1;
            step();
            op_ready = 1'b0;
         end else begin
            op_ready = 1'b1;
            step();
            op_ready = timing;
         end

         if (n < N - 1) begin
            check("idx_advance", neuron_idx, n + 1);
         end else begin
            check("done_pulse", done, 1);
            check("busy_fall", busy, 0);
            if (timing) check("done_time", step_cnt - t0, 1121);
            step();
            check("done_one_cycle", done, 0);
         end
      end
      act_valid = 1'b0;
      op_ready  = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset1    = 1'b1;
      start     = 1'b0;
      act_valid = 1'b0;
      act_data  = '0;
      op_ready  = 1'b0;
      biases    = '0;
      rom_data  = '0;
      for (int a = 0; a < 1024; a++) rom_mem[a] = 4'(a % 16);

      // Reset behaviour; start while reset is held must be ignored.
      step();
      step();
      check_idle_outputs("reset");
      start = 1'b1;
      step();
      start = 1'b0;
      check("start_in_reset_busy", busy, 0);
      check("start_in_reset_ready", act_ready, 0);
      reset1 = 1'b0;
      step();
      check("post_reset_idle", busy, 0);

      // Image 1: directed quantisation ramp, address-pattern ROM, back-pressure.
      for (int i = 0; i < H; i++) act_tbl[i] = i % 256;
      act_tbl[99] = 255;
      for (int n = 0; n < N; n++) bias_tbl[n] = n;
      run_image(1'b0, 1'b1, 1'b0, -1);
      check("q_slot99_sat", input_features[4*99 +: 4], 15);
      check("q_slot40", input_features[4*40 +: 4], 5);
      check("q_slot7", input_features[4*7 +: 4], 0);

      // Image 2: random data, continuous stimulus, cycle-exact timing.
      for (int a = 0; a < 1024; a++) rom_mem[a] = 4'($urandom);
      for (int i = 0; i < H; i++) act_tbl[i] = int'($urandom_range(0, 255));
      run_image(1'b0, 1'b0, 1'b1, -1);

      // Image 3: random gaps, reset during fetch of neuron 4.
      for (int i = 0; i < H; i++) act_tbl[i] = int'($urandom_range(0, 255));
      for (int n = 0; n < N; n++) bias_tbl[n] = int'($urandom_range(0, 7));
      run_image(1'b1, 1'b0, 1'b0, 4);

      // Image 4: fresh image after the abort.
      for (int a = 0; a < 1024; a++) rom_mem[a] = 4'($urandom);
      for (int i = 0; i < H; i++) act_tbl[i] = int'($urandom_range(0, 255));
      for (int n = 0; n < N; n++) bias_tbl[n] = int'($urandom_range(0, 7));
      run_image(1'b1, 1'b0, 1'b0, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
